// File: rtl/scr1_tcm_arb_pkg.sv
// Shared types and lane helpers for the single-port TCM arbiter.
// Byte-enable and write-data alignment live here so the checker and top agree on width encoding.
package scr1_tcm_arb_pkg;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_IMEM = 2'b01,
    RSP_DMEM = 2'b10
  } rsp_owner_e;

  function automatic logic [3:0] calc_web(input type_scr1_mem_width_e width,
                                          input logic [1:0]           offs);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return 4'b0001 << offs;
      SCR1_MEM_WIDTH_HWORD: return 4'b0011 << offs;
      SCR1_MEM_WIDTH_WORD:  return 4'b1111;
      default:              return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] align_wdata(input type_scr1_mem_width_e width,
                                              input logic [31:0]          wdata);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return {4{wdata[7:0]}};
      SCR1_MEM_WIDTH_HWORD: return {2{wdata[15:0]}};
      default:              return wdata;
    endcase
  endfunction

endpackage

// File: rtl/scr1_tcm_req_chk.sv
// Combinational range/alignment/width check on the granted request.
// Zero latency; no state, no flow control.
module scr1_tcm_req_chk
  import scr1_tcm_arb_pkg::*;
#(
  parameter int          AW            = 16,
  parameter logic [31:0] SCR1_TCM_BASE = 32'h00480000
) (
  input  logic [31:AW]         addr_hi,
  input  logic [1:0]           addr_lo,
  input  type_scr1_mem_width_e width,
  output logic                 err
);

  localparam logic [31:0] BASE_W = SCR1_TCM_BASE;

  logic misalign;

  always_comb begin
    misalign = 1'b0;
    case (width)
      SCR1_MEM_WIDTH_HWORD: misalign = addr_lo[0];
      SCR1_MEM_WIDTH_WORD:  misalign = |addr_lo;
      default:              misalign = 1'b0;
    endcase
  end

  assign err = (addr_hi != BASE_W[31:AW]) | misalign | (width == SCR1_MEM_WIDTH_ERROR);

endmodule

// File: rtl/scr1_tcm_sp_arb.sv
// Shares one single-port TCM between fetch and data ports: combinational ack, one access per cycle,
// registered response next cycle; dmem has priority until imem has been blocked STARVE_LIMIT times.
module scr1_tcm_sp_arb
  import scr1_tcm_arb_pkg::*;
#(
  parameter logic [31:0] SCR1_TCM_SIZE = 32'h00010000,
  parameter logic [31:0] SCR1_TCM_BASE = 32'h00480000,
  parameter int          STARVE_LIMIT  = 4,
  localparam int         AW            = $clog2(SCR1_TCM_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          imem_req,
  input  logic [31:0]   imem_addr,
  output logic          imem_req_ack,
  output logic [31:0]   imem_rdata,
  output logic [1:0]    imem_resp,
  input  logic          dmem_req,
  input  logic          dmem_cmd,
  input  logic [1:0]    dmem_width,
  input  logic [31:0]   dmem_addr,
  input  logic [31:0]   dmem_wdata,
  output logic          dmem_req_ack,
  output logic [31:0]   dmem_rdata,
  output logic [1:0]    dmem_resp,
  output logic          mem_rena,
  output logic          mem_wena,
  output logic [3:0]    mem_web,
  output logic [AW-3:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_qa
);

  logic                 grant_imem;
  logic                 grant_dmem;
  logic                 grant_any;
  logic                 win_wr;
  logic [31:0]          win_addr;
  type_scr1_mem_width_e win_width;
  logic                 req_err;
  logic [3:0]           starve_cnt;

  rsp_owner_e           rsp_owner;
  logic                 rsp_err;
  logic                 rsp_read;
  logic                 rsp_rd_ok;

  always_comb begin
    grant_imem = imem_req & (~dmem_req | (starve_cnt == 4'(STARVE_LIMIT)));
    grant_dmem = dmem_req & ~grant_imem;
    grant_any  = grant_imem | grant_dmem;
    win_addr   = grant_imem ? imem_addr : dmem_addr;
    // Fetches are always word reads, so they share the word alignment rule.
    win_width  = grant_imem ? SCR1_MEM_WIDTH_WORD : type_scr1_mem_width_e'(dmem_width);
    win_wr     = grant_dmem & (dmem_cmd == SCR1_MEM_CMD_WR);
  end

  scr1_tcm_req_chk #(
    .AW            (AW),
    .SCR1_TCM_BASE (SCR1_TCM_BASE)
  ) u_req_chk (
    .addr_hi (win_addr[31:AW]),
    .addr_lo (win_addr[1:0]),
    .width   (win_width),
    .err     (req_err)
  );

  always_comb begin
    mem_rena  = grant_any & ~req_err & ~win_wr;
    mem_wena  = grant_any & ~req_err & win_wr;
    mem_web   = mem_wena ? calc_web(win_width, win_addr[1:0]) : 4'b0000;
    mem_addr  = (mem_rena | mem_wena) ? win_addr[AW-1:2] : '0;
    mem_wdata = mem_wena ? align_wdata(win_width, dmem_wdata) : '0;
  end

  assign imem_req_ack = grant_imem;
  assign dmem_req_ack = grant_dmem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (grant_dmem & imem_req) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_owner <= RSP_NONE;
      rsp_err   <= 1'b0;
      rsp_read  <= 1'b0;
    end else begin
      rsp_owner <= grant_imem ? RSP_IMEM : (grant_dmem ? RSP_DMEM : RSP_NONE);
      rsp_err   <= grant_any & req_err;
      rsp_read  <= grant_any & ~win_wr;
    end
  end

  assign rsp_rd_ok = ~rsp_err & rsp_read;

  always_comb begin
    imem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    imem_rdata = '0;
    dmem_rdata = '0;
    if (rsp_owner == RSP_IMEM) begin
      imem_resp  = rsp_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      imem_rdata = rsp_rd_ok ? mem_qa : '0;
    end
    if (rsp_owner == RSP_DMEM) begin
      dmem_resp  = rsp_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      dmem_rdata = rsp_rd_ok ? mem_qa : '0;
    end
  end

endmodule

// File: tb/tb_scr1_tcm_sp_arb.sv
// Directed bench for scr1_tcm_sp_arb with a one-cycle-latency TCM model.
// Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
module tb_scr1_tcm_sp_arb;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_req_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_req_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;
  logic        mem_rena;
  logic        mem_wena;
  logic [3:0]  mem_web;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_qa;

  logic [31:0] tb_mem [0:15];
  int          passed;
  int          total;
  int          fails;

  scr1_tcm_sp_arb #(
    .SCR1_TCM_SIZE (32'h00010000),
    .SCR1_TCM_BASE (32'h00480000),
    .STARVE_LIMIT  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_req_ack (imem_req_ack),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_req_ack (dmem_req_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .mem_rena     (mem_rena),
    .mem_wena     (mem_wena),
    .mem_web      (mem_web),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_qa       (mem_qa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preloaded while reset is held, read data one cycle after rena.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < 16; w++) tb_mem[w] <= 32'h0;
      tb_mem[0] <= 32'h11223344;
      tb_mem[4] <= 32'hDEADBEEF;
      mem_qa    <= 32'h0;
    end else begin
      if (mem_rena) mem_qa <= tb_mem[mem_addr[3:0]];
      if (mem_wena) begin
        for (int b = 0; b < 4; b++)
          if (mem_web[b]) tb_mem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    passed = 0; total = 0; fails = 0;
    rst_n = 1'b0;
    imem_req = 1'b0; imem_addr = 32'h0;
    dmem_req = 1'b0; dmem_cmd = 1'b0; dmem_width = 2'b00;
    dmem_addr = 32'h0; dmem_wdata = 32'h0;
    repeat (3) cyc();
    #1;
    chk("rst_imem_ack",  imem_req_ack, 0);
    chk("rst_dmem_ack",  dmem_req_ack, 0);
    chk("rst_imem_resp", imem_resp, 0);
    chk("rst_dmem_resp", dmem_resp, 0);
    chk("rst_rena",      mem_rena, 0);
    chk("rst_wena",      mem_wena, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // 1: fetch read at 0x00480010
    imem_req = 1'b1; imem_addr = 32'h00480010;
    #1;
    chk("t1_ack",   imem_req_ack, 1);
    chk("t1_rena",  mem_rena, 1);
    chk("t1_addr",  mem_addr, 4);
    chk("t1_web",   mem_web, 0);
    cyc();
    imem_req = 1'b0;
    #1;
    chk("t1_resp",  imem_resp, 1);
    chk("t1_rdata", imem_rdata, 32'hDEADBEEF);
    chk("t1_dresp", dmem_resp, 0);

    // 2: byte write 0xA5 at offset 3, then word read back
    cyc();
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'b00;
    dmem_addr = 32'h00480003; dmem_wdata = 32'h5A5A5AA5;
    #1;
    chk("t2_ack",   dmem_req_ack, 1);
    chk("t2_wena",  mem_wena, 1);
    chk("t2_rena",  mem_rena, 0);
    chk("t2_web",   mem_web, 4'b1000);
    chk("t2_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("t2_waddr", mem_addr, 0);
    cyc();
    dmem_cmd = 1'b0; dmem_width = 2'b10; dmem_addr = 32'h00480000;
    #1;
    chk("t2_wr_resp",  dmem_resp, 1);
    chk("t2_wr_rdata", dmem_rdata, 0);
    chk("t2_rd_rena",  mem_rena, 1);
    chk("t2_rd_web",   mem_web, 0);
    cyc();
    dmem_req = 1'b0;
    #1;
    chk("t2_rd_resp",  dmem_resp, 1);
    chk("t2_rd_rdata", dmem_rdata, 32'hA5223344);

    // 3: both requesting continuously -> D,D,D,D,I
    cyc();
    imem_req = 1'b1; imem_addr = 32'h00480010;
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'b10; dmem_addr = 32'h00480000;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_iack", imem_req_ack, (i % 5 == 4) ? 1 : 0);
      chk("t3_dack", dmem_req_ack, (i % 5 == 4) ? 0 : 1);
      cyc();
      chk("t3_iresp", imem_resp, (i % 5 == 4) ? 1 : 0);
      chk("t3_dresp", dmem_resp, (i % 5 == 4) ? 0 : 1);
      if (i % 5 == 4) chk("t3_irdata", imem_rdata, 32'hDEADBEEF);
      else            chk("t3_drdata", dmem_rdata, 32'hA5223344);
    end
    imem_req = 1'b0; dmem_req = 1'b0;
    cyc();

    // 4: misaligned half read, then out-of-range word read
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'b01; dmem_addr = 32'h00480001;
    #1;
    chk("t4a_ack",  dmem_req_ack, 1);
    chk("t4a_rena", mem_rena, 0);
    cyc();
    dmem_width = 2'b10; dmem_addr = 32'h00490000;
    #1;
    chk("t4a_resp",  dmem_resp, 2);
    chk("t4a_rdata", dmem_rdata, 0);
    chk("t4b_ack",   dmem_req_ack, 1);
    chk("t4b_rena",  mem_rena, 0);
    cyc();
    dmem_req = 1'b0;
    #1;
    chk("t4b_resp",  dmem_resp, 2);
    cyc();

    // 5: simultaneous, dmem misaligned word write loses to error, imem next
    imem_req = 1'b1; imem_addr = 32'h00480010;
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'b10;
    dmem_addr = 32'h00480002; dmem_wdata = 32'hFFFFFFFF;
    #1;
    chk("t5_dack", dmem_req_ack, 1);
    chk("t5_iack", imem_req_ack, 0);
    chk("t5_wena", mem_wena, 0);
    chk("t5_rena", mem_rena, 0);
    cyc();
    dmem_req = 1'b0;
    #1;
    chk("t5_dresp",  dmem_resp, 2);
    chk("t5_iack2",  imem_req_ack, 1);
    chk("t5_irena",  mem_rena, 1);
    cyc();
    imem_req = 1'b0;
    #1;
    chk("t5_iresp",  imem_resp, 1);
    chk("t5_irdata", imem_rdata, 32'hDEADBEEF);
    chk("t5_mem0",   tb_mem[0], 32'hA5223344);
    cyc();

    // 6: reset right after an ack drops the pending response
    imem_req = 1'b1; imem_addr = 32'h00480010;
    #1;
    chk("t6_ack", imem_req_ack, 1);
    cyc();
    imem_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_iresp_rst",  imem_resp, 0);
    chk("t6_dresp_rst",  dmem_resp, 0);
    chk("t6_irdata_rst", imem_rdata, 0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("t6_iresp_rel", imem_resp, 0);
    cyc();
    #1;
    chk("t6_iresp_after", imem_resp, 0);
    chk("t6_dresp_after", dmem_resp, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
